// File: rtl/niospherisys_onchip_mem_arbiter.sv
// Two-port round-robin Avalon-MM arbiter in front of a single-port on-chip RAM.
// One access per cycle; read returns are steered back to the issuing port.
module niospherisys_onchip_mem_arbiter #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 5750
) (
    input  logic                clk,
    input  logic                reset,

    input  logic [ADDR_W-1:0]   s0_address,
    input  logic [DATA_W/8-1:0] s0_byteenable,
    input  logic                s0_read,
    input  logic                s0_write,
    input  logic [DATA_W-1:0]   s0_writedata,
    output logic                s0_waitrequest,
    output logic [DATA_W-1:0]   s0_readdata,
    output logic                s0_readdatavalid,

    input  logic [ADDR_W-1:0]   s1_address,
    input  logic [DATA_W/8-1:0] s1_byteenable,
    input  logic                s1_read,
    input  logic                s1_write,
    input  logic [DATA_W-1:0]   s1_writedata,
    output logic                s1_waitrequest,
    output logic [DATA_W-1:0]   s1_readdata,
    output logic                s1_readdatavalid,

    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);

    logic req0, req1;
    logic grant0, grant1, any_grant;
    logic sel_read, sel_write, sel_oor;
    logic last_grant, rd_pend, rd_port, rd_oor;

    always_comb begin
        req0 = s0_read | s0_write;
        req1 = s1_read | s1_write;

        // On contention the port that did not win last time gets the slot.
        grant0    = ~reset & req0 & (~req1 | last_grant);
        grant1    = ~reset & req1 & (~req0 | ~last_grant);
        any_grant = grant0 | grant1;

        s0_waitrequest = reset | (req0 & ~grant0);
        s1_waitrequest = reset | (req1 & ~grant1);

        mem_address    = grant1 ? s1_address    : s0_address;
        mem_byteenable = grant1 ? s1_byteenable : s0_byteenable;
        mem_writedata  = grant1 ? s1_writedata  : s0_writedata;
        sel_read       = grant1 ? s1_read       : s0_read;
        sel_write      = grant1 ? s1_write      : s0_write;
        sel_oor        = 32'(mem_address) >= DEPTH;

        mem_chipselect = any_grant & ~sel_oor;
        mem_write      = mem_chipselect & sel_write;
        mem_clken      = ~reset;

        s0_readdatavalid = rd_pend & ~rd_port;
        s1_readdatavalid = rd_pend & rd_port;
        s0_readdata      = (s0_readdatavalid & ~rd_oor) ? mem_readdata : '0;
        s1_readdata      = (s1_readdatavalid & ~rd_oor) ? mem_readdata : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
            rd_pend    <= 1'b0;
            rd_port    <= 1'b0;
            rd_oor     <= 1'b0;
        end else begin
            // A read+write collision on one port is treated as a write only.
            rd_pend <= any_grant & sel_read & ~sel_write;
            if (any_grant) begin
                last_grant <= grant1;
                rd_port    <= grant1;
                rd_oor     <= sel_oor;
            end
        end
    end

endmodule

// File: doc/niospherisys_onchip_mem_arbiter.md
# niospherisys_onchip_mem_arbiter

Two-port Avalon-MM arbiter feeding the single-port 32-bit on-chip memory (5750 words, 13-bit word address, byte enables, 1-cycle read latency). Port 0 serves the Nios II data master and port 1 serves a secondary master (DMA or debug). The block grants one access per cycle round-robin, drives the memory port, and steers registered read returns back to the issuing port with `readdatavalid`.

## Interface
- `ADDR_W`, 13: word address width, shared by both slave ports and the memory port.
- `DATA_W`, 32: data width; byte-enable width is `DATA_W/8`.
- `DEPTH`, 5750: number of implemented memory words; addresses `>= DEPTH` are out of range.
- `clk`  in  1  single clock for the whole block.
- `reset`  in  1  asynchronous, active-high reset.
- `s0_address` / `s1_address`  in  `ADDR_W`  word address.
- `s0_byteenable` / `s1_byteenable`  in  4  byte lanes for writes; ignored on reads.
- `s0_read` / `s1_read`  in  1  read request.
- `s0_write` / `s1_write`  in  1  write request.
- `s0_writedata` / `s1_writedata`  in  32  write data.
- `s0_waitrequest` / `s1_waitrequest`  out  1  request not accepted this cycle.
- `s0_readdata` / `s1_readdata`  out  32  read return data.
- `s0_readdatavalid` / `s1_readdatavalid`  out  1  read return strobe.
- `mem_address`  out  `ADDR_W`  to memory `address`.
- `mem_byteenable`  out  4  to memory `byteenable`.
- `mem_chipselect`  out  1  to memory `chipselect`.
- `mem_write`  out  1  to memory `write`.
- `mem_writedata`  out  32  to memory `writedata`.
- `mem_clken`  out  1  to memory `clken`; held 1 outside reset.
- `mem_readdata`  in  32  from memory `readdata`.

## Operation
- Request on port N: `sN_read | sN_write`. A request is accepted in any cycle where it is asserted and `sN_waitrequest` = 0.
- Arbitration is combinational from the requests and register `last_grant`.
  - Exactly one port requesting: that port is granted.
  - Both ports requesting: the port ≠ `last_grant` is granted.
  - `last_grant` updates on every accepted request.
  - Reset value of `last_grant` = 1, so port 0 wins the first contention.
- `sN_waitrequest` = `reset | (sN_req & ~grantN)`. An idle port sees `waitrequest` = 0.
- Granted access drives the memory port:
  - `mem_chipselect` = 1.
  - `mem_address`, `mem_byteenable`, `mem_writedata` muxed from the granted port.
  - `mem_write` = the granted port's `write`.
  - With no grant, `mem_chipselect` = 0, `mem_write` = 0, and the other memory outputs hold the port 0 values.
- Read and write asserted together on one port is a protocol violation. The write wins and no read return is generated.
- Out-of-range access (`address >= DEPTH`):
  - Accepted normally (no stall).
  - Write: `mem_chipselect` and `mem_write` forced to 0, so the write is dropped.
  - Read: `mem_chipselect` forced to 0; the return carries data 0x00000000.
- Read-return tracking uses three registers:
  - `rd_pend` (1 bit): set by an accepted read, otherwise cleared.
  - `rd_port` (1 bit): the port that issued the read.
  - `rd_oor` (1 bit): the read was out of range.
- Return path:
  - `sN_readdatavalid` = `rd_pend & (rd_port == N)`.
  - `sN_readdata` = `mem_readdata` when valid and not `rd_oor`, else 0x00000000.
  - The non-returning port always sees 0.

## Timing
- Write latency: an accepted write at edge T is in memory after edge T; a read accepted at T+1 to the same address returns the new data.
- Read latency: accepted at edge T, so `readdatavalid` is high and data valid for exactly the cycle following edge T.
- Throughput: one access per cycle total. Back-to-back reads from either or both ports give continuous returns.
- Fairness: under continuous contention, grants alternate 0,1,0,1. No port waits more than 1 cycle.
- Reset (asynchronous, any time):
  - `rd_pend` = 0 and `last_grant` = 1 immediately.
  - All `readdatavalid` = 0 and all `readdata` = 0.
  - Both `waitrequest` = 1.
  - `mem_chipselect` = 0, `mem_write` = 0, `mem_clken` = 0.
  - A read in flight when reset asserts is dropped and never returns after reset releases.
- After reset deasserts, the first request is grantable in the same cycle.

## Test plan
- Single read/write: port 0 writes 0xA5A5_1234 with byteenable 0xF to address 0x0010, then reads 0x0010. Required: `s0_readdatavalid` one cycle after acceptance, data 0xA5A5_1234, `s1_readdatavalid` stays 0.
- Byte lanes: write 0xFFFFFFFF, then 0x00000000 with byteenable 0x5 to address 0x0020, then read. Required: 0xFF00FF00.
- Contention: both ports read continuously for 6 cycles to different preloaded addresses. Required: grants 0,1,0,1,0,1; each `waitrequest` high on alternate cycles; every return reaches the correct port with the correct data.
- Out of range: port 1 writes 0xDEADBEEF to address 5750 and reads 5750 and 8191. Required: `mem_chipselect` stays 0, both reads return 0x00000000 with `readdatavalid`; address 5749 is unaffected.
- Reset mid-read: accept a port 0 read, assert `reset` asynchronously before the next edge. Required: no `readdatavalid` during or after reset, `last_grant` = 1, and the first contention after release grants port 0.
